// File: rtl/hazard_fwd_unit_pkg.sv
// hazard_fwd_unit_pkg
// Shared pipeline definitions for the hazard/forwarding unit. It holds the
// operand-select encodings driven into the EX operand muxes, the stall FSM
// state type, the hard-wired zero register index, and a helper that checks
// whether a producer's destination may feed a consumer's source.
// No ports (package).

package hazard_fwd_unit_pkg;

  // EX operand mux select encodings
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // $0 always reads as zero, so it never produces a dependency
  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic {
    RUN,
    STALL
  } stallState_e;

  // True when a write to 'dst' produces the value a read of 'src' needs
  function automatic logic regHit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
// Bundles the pipeline-facing signals of the hazard/forwarding unit.
//   master : the pipeline side, drives the ID and ID/EX fields, receives
//            the forwarding selects, stall/flush controls and counters.
//   slave  : the hazard unit itself.
// Signals:
//   id_rs, id_rt, id_uses_rt             register fields of the ID instruction
//   ex_rs, ex_rt, ex_wr_addr             register fields leaving ID/EX
//   ex_RegWrite, ex_MemRead, ex_Branch,
//   ex_JtoPC, ex_zero                    control/status of the EX instruction
//   fwdA, fwdB                           EX operand selects
//   pc_write, ifid_write, ifid_flush,
//   idex_bubble, pc_redirect             pipeline steering controls
//   stall_cnt, flush_cnt                 saturating event counters

interface hazard_fwd_unit_if #(
  parameter int CNT_W = 16
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_wr_addr;
  logic             ex_RegWrite;
  logic             ex_MemRead;
  logic             ex_Branch;
  logic             ex_JtoPC;
  logic             ex_zero;
  logic [1:0]       fwdA;
  logic [1:0]       fwdB;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pc_redirect;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt,
    output ex_rs, ex_rt, ex_wr_addr,
    output ex_RegWrite, ex_MemRead, ex_Branch, ex_JtoPC, ex_zero,
    input  fwdA, fwdB,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt,
    input  ex_rs, ex_rt, ex_wr_addr,
    input  ex_RegWrite, ex_MemRead, ex_Branch, ex_JtoPC, ex_zero,
    output fwdA, fwdB,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_select.sv
// fwd_select
// Per-operand forwarding comparator. Picks where one EX source operand
// should come from, given the shadowed EX/MEM and MEM/WB destinations.
// Ports:
//   memRw_i, memWr_i  RegWrite / destination of the instruction in MEM
//   wbRw_i,  wbWr_i   RegWrite / destination of the instruction in WB
//   exReg_i           source register read by the EX instruction
//   fwdSel_o          operand select (FWD_REG / FWD_EXMEM / FWD_MEMWB)

module fwd_select
  import hazard_fwd_unit_pkg::*;
(
  input  logic       memRw_i,
  input  logic [4:0] memWr_i,
  input  logic       wbRw_i,
  input  logic [4:0] wbWr_i,
  input  logic [4:0] exReg_i,
  output logic [1:0] fwdSel_o
);

  // The younger producer (EX/MEM) holds the newest value, so it is checked
  // first; MEM/WB only forwards when EX/MEM does not match.
  always_comb begin
    fwdSel_o = FWD_REG;
    if (memRw_i && regHit(memWr_i, exReg_i)) begin
      fwdSel_o = FWD_EXMEM;
    end else if (wbRw_i && regHit(wbWr_i, exReg_i)) begin
      fwdSel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Consumer-side companion to the ID/EX register. Each cycle it chooses the
// EX operand forwarding paths, inserts load-use bubbles and flushes the
// front end on taken branches/jumps. It keeps its own shadow of the EX/MEM
// and MEM/WB destinations, a small stall FSM and two event counters.
// Ports:
//   CLK   rising-edge clock
//   RSTn  asynchronous active-low reset
//   bus   hazard_fwd_unit_if.slave (see the interface for signal list)
// Parameters:
//   LOAD_STALL_CYC  bubbles per load-use hazard (1..3)
//   CNT_W           counter width

module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 16
) (
  input  logic               CLK,
  input  logic               RSTn,
  hazard_fwd_unit_if.slave   bus
);

  localparam logic [1:0]       STALL_INIT = 2'(LOAD_STALL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  stallState_e      state_q, stateD;
  logic [1:0]       stallLeft_q, stallLeftD;
  logic [4:0]       memWr_q, wbWr_q;
  logic             memRw_q, wbRw_q;
  logic [CNT_W-1:0] stallCnt_q, stallCntD;
  logic [CNT_W-1:0] flushCnt_q, flushCntD;

  logic taken;
  logic hz;
  logic pcWrite;
  logic ifidWrite;
  logic ifidFlush;
  logic idexBubble;
  logic pcRedirect;

  // Operand forwarding, one comparator per EX source operand
  fwd_select uFwdA (
    .memRw_i  (memRw_q),
    .memWr_i  (memWr_q),
    .wbRw_i   (wbRw_q),
    .wbWr_i   (wbWr_q),
    .exReg_i  (bus.ex_rs),
    .fwdSel_o (bus.fwdA)
  );

  fwd_select uFwdB (
    .memRw_i  (memRw_q),
    .memWr_i  (memWr_q),
    .wbRw_i   (wbRw_q),
    .wbWr_i   (wbWr_q),
    .exReg_i  (bus.ex_rt),
    .fwdSel_o (bus.fwdB)
  );

  // Pipeline steering. A taken redirect always wins over a load-use stall,
  // because the instruction in ID is about to be flushed anyway. While
  // reset is asserted the pipeline is forced to free-run with no flush,
  // so a reset in the middle of a stall releases the PC straight away.
  always_comb begin
    taken      = bus.ex_JtoPC || (bus.ex_Branch && bus.ex_zero);
    hz         = bus.ex_MemRead &&
                 (regHit(bus.ex_wr_addr, bus.id_rs) ||
                  (bus.id_uses_rt && regHit(bus.ex_wr_addr, bus.id_rt)));
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pcRedirect = 1'b0;
    if (RSTn) begin
      if (taken) begin
        pcRedirect = 1'b1;
        ifidFlush  = 1'b1;
        idexBubble = 1'b1;
      end else if (state_q == STALL || hz) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b1;
      end
    end
  end

  // Next-state for the stall FSM and the saturating counters. The first
  // bubble is issued from RUN, so STALL only covers the remaining
  // LOAD_STALL_CYC-1 cycles; with a single-cycle stall it is never entered.
  always_comb begin
    stateD     = state_q;
    stallLeftD = stallLeft_q;
    case (state_q)
      RUN: begin
        if (!taken && hz && (LOAD_STALL_CYC > 1)) begin
          stateD     = STALL;
          stallLeftD = STALL_INIT;
        end
      end
      STALL: begin
        if (taken || stallLeft_q <= 2'd1) begin
          stateD = RUN;
        end else begin
          stallLeftD = stallLeft_q - 2'd1;
        end
      end
      default: stateD = RUN;
    endcase

    stallCntD = stallCnt_q;
    if (!pcWrite && stallCnt_q != CNT_MAX) begin
      stallCntD = stallCnt_q + CNT_ONE;
    end
    flushCntD = flushCnt_q;
    if (pcRedirect && flushCnt_q != CNT_MAX) begin
      flushCntD = flushCnt_q + CNT_ONE;
    end
  end

  // State registers. The destination shadows follow the EX instruction down
  // the pipe every cycle; bubbles arrive with RegWrite low so they never
  // forward.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= RUN;
      stallLeft_q <= 2'd0;
      memWr_q     <= REG_ZERO;
      memRw_q     <= 1'b0;
      wbWr_q      <= REG_ZERO;
      wbRw_q      <= 1'b0;
      stallCnt_q  <= '0;
      flushCnt_q  <= '0;
    end else begin
      state_q     <= stateD;
      stallLeft_q <= stallLeftD;
      memWr_q     <= bus.ex_wr_addr;
      memRw_q     <= bus.ex_RegWrite;
      wbWr_q      <= memWr_q;
      wbRw_q      <= memRw_q;
      stallCnt_q  <= stallCntD;
      flushCnt_q  <= flushCntD;
    end
  end

  assign bus.pc_write    = pcWrite;
  assign bus.ifid_write  = ifidWrite;
  assign bus.ifid_flush  = ifidFlush;
  assign bus.idex_bubble = idexBubble;
  assign bus.pc_redirect = pcRedirect;
  assign bus.stall_cnt   = stallCnt_q;
  assign bus.flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// Directed bench for hazard_fwd_unit. Two instances run side by side: one
// with single-cycle load stalls and one with three-cycle stalls. Each step
// drives one instance, pushes the expected outputs onto a scoreboard and
// pops/compares them once the combinational outputs have settled.

module tb_hazard_fwd_unit;
  import hazard_fwd_unit_pkg::*;

  localparam int K_RUN = 0;
  localparam int K_STL = 1;
  localparam int K_RED = 2;

  // Field order: idRs, idRt, uses, exRs, exRt, exWr, rw, mr, br, j, z
  typedef struct packed {
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       uses;
    logic [4:0] exRs;
    logic [4:0] exRt;
    logic [4:0] exWr;
    logic       rw;
    logic       mr;
    logic       br;
    logic       j;
    logic       z;
  } stim_t;

  typedef struct packed {
    logic        d3;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        rd;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  int compared = 0;
  int failed   = 0;

  exp_t  sbQ[$];
  string tagQ[$];

  always #5 CLK = ~CLK;

  hazard_fwd_unit_if #(.CNT_W(16)) busA ();
  hazard_fwd_unit_if #(.CNT_W(16)) busC ();

  hazard_fwd_unit #(.LOAD_STALL_CYC(1), .CNT_W(16)) dut1 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (busA)
  );

  hazard_fwd_unit #(.LOAD_STALL_CYC(3), .CNT_W(16)) dut3 (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (busC)
  );

  // Expected-value builder: kind selects the steering pattern
  function automatic exp_t mkE(input logic d3, input logic [1:0] fa, input logic [1:0] fb,
                               input int kind, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    e.d3 = d3;
    e.fa = fa;
    e.fb = fb;
    e.sc = sc;
    e.fc = fc;
    e.pcw = (kind != K_STL);
    e.ifw = (kind != K_STL);
    e.fl  = (kind == K_RED);
    e.bub = (kind != K_RUN);
    e.rd  = (kind == K_RED);
    return e;
  endfunction

  task automatic setA(input stim_t s);
    busA.id_rs       = s.idRs;
    busA.id_rt       = s.idRt;
    busA.id_uses_rt  = s.uses;
    busA.ex_rs       = s.exRs;
    busA.ex_rt       = s.exRt;
    busA.ex_wr_addr  = s.exWr;
    busA.ex_RegWrite = s.rw;
    busA.ex_MemRead  = s.mr;
    busA.ex_Branch   = s.br;
    busA.ex_JtoPC    = s.j;
    busA.ex_zero     = s.z;
  endtask

  task automatic setC(input stim_t s);
    busC.id_rs       = s.idRs;
    busC.id_rt       = s.idRt;
    busC.id_uses_rt  = s.uses;
    busC.ex_rs       = s.exRs;
    busC.ex_rt       = s.exRt;
    busC.ex_wr_addr  = s.exWr;
    busC.ex_RegWrite = s.rw;
    busC.ex_MemRead  = s.mr;
    busC.ex_Branch   = s.br;
    busC.ex_JtoPC    = s.j;
    busC.ex_zero     = s.z;
  endtask

  // Drive the target instance, idle the other one, queue the expectation
  task automatic applyStimulus(input string tag, input logic d3, input stim_t s, input exp_t e);
    stim_t idle;
    idle = '0;
    if (d3) begin
      setC(s);
      setA(idle);
    end else begin
      setA(s);
      setC(idle);
    end
    sbQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic cmp(input string tag, input string name, input logic [15:0] obs, input logic [15:0] ex);
    compared++;
    assert (obs === ex) else begin
      failed++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, name, obs, ex);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string t;
    logic [1:0]  fa, fb;
    logic        pcw, ifw, fl, bub, rd;
    logic [15:0] sc, fc;
    if (sbQ.size() == 0) begin
      compared++;
      failed++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sbQ.pop_front();
    t = tagQ.pop_front();
    if (e.d3) begin
      fa = busC.fwdA; fb = busC.fwdB; pcw = busC.pc_write; ifw = busC.ifid_write;
      fl = busC.ifid_flush; bub = busC.idex_bubble; rd = busC.pc_redirect;
      sc = busC.stall_cnt; fc = busC.flush_cnt;
    end else begin
      fa = busA.fwdA; fb = busA.fwdB; pcw = busA.pc_write; ifw = busA.ifid_write;
      fl = busA.ifid_flush; bub = busA.idex_bubble; rd = busA.pc_redirect;
      sc = busA.stall_cnt; fc = busA.flush_cnt;
    end
    cmp(t, "fwdA",        16'(fa),  16'(e.fa));
    cmp(t, "fwdB",        16'(fb),  16'(e.fb));
    cmp(t, "pc_write",    16'(pcw), 16'(e.pcw));
    cmp(t, "ifid_write",  16'(ifw), 16'(e.ifw));
    cmp(t, "ifid_flush",  16'(fl),  16'(e.fl));
    cmp(t, "idex_bubble", 16'(bub), 16'(e.bub));
    cmp(t, "pc_redirect", 16'(rd),  16'(e.rd));
    cmp(t, "stall_cnt",   sc,       e.sc);
    cmp(t, "flush_cnt",   fc,       e.fc);
  endtask

  task automatic step(input string tag, input logic d3, input stim_t s, input exp_t e);
    @(posedge CLK);
    #1;
    applyStimulus(tag, d3, s, e);
    #2;
    checkOutput();
  endtask

  // Hard stop in case the sequence ever stalls on the clock
  initial begin
    #50000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t idle;
    idle = '0;

    // Outputs during reset must be the free-running defaults even with a
    // jump and a load-use hazard presented
    #1;
    applyStimulus("reset1", 1'b0, '{8, 0, 0, 0, 0, 8, 1, 1, 1, 1, 1}, mkE(0, FWD_REG, FWD_REG, K_RUN, 0, 0));
    #2;
    checkOutput();
    applyStimulus("reset3", 1'b1, '{8, 0, 0, 0, 0, 8, 1, 1, 1, 1, 1}, mkE(1, FWD_REG, FWD_REG, K_RUN, 0, 0));
    #1;
    checkOutput();
    @(negedge CLK);
    setA(idle);
    setC(idle);
    RSTn = 1'b1;

    // Forwarding on the single-cycle instance
    step("add3",        0, '{3, 4, 1, 1, 2, 3, 1, 0, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RUN, 0, 0));
    step("sub_fwdA",    0, '{0, 0, 0, 3, 4, 6, 1, 0, 0, 0, 0}, mkE(0, FWD_EXMEM, FWD_REG,   K_RUN, 0, 0));
    step("wb_fwd",      0, '{0, 0, 0, 3, 6, 5, 1, 0, 0, 0, 0}, mkE(0, FWD_MEMWB, FWD_EXMEM, K_RUN, 0, 0));
    step("rs_zero",     0, '{0, 0, 0, 0, 9, 5, 1, 0, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RUN, 0, 0));
    step("double",      0, '{0, 0, 0, 5, 5, 0, 1, 0, 0, 0, 0}, mkE(0, FWD_EXMEM, FWD_EXMEM, K_RUN, 0, 0));
    step("zero_mem",    0, '{0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0}, mkE(0, FWD_REG,   FWD_MEMWB, K_RUN, 0, 0));
    step("zero_wb",     0, '{0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RUN, 0, 0));
    // Load-use with a one-bubble stall
    step("load_use",    0, '{8, 0, 0, 7, 0, 8, 1, 1, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_STL, 0, 0));
    step("after_load",  0, '{0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0}, mkE(0, FWD_EXMEM, FWD_REG,   K_RUN, 1, 0));
    step("load_wb",     0, '{0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0}, mkE(0, FWD_MEMWB, FWD_REG,   K_RUN, 1, 0));
    // Redirects
    step("redir_hz",    0, '{9, 0, 0, 0, 0, 9, 1, 1, 1, 0, 1}, mkE(0, FWD_REG,   FWD_REG,   K_RED, 1, 0));
    step("post_redir",  0, idle,                                mkE(0, FWD_REG,   FWD_REG,   K_RUN, 1, 1));
    step("jump",        0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RED, 1, 1));
    step("br_nt",       0, '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RUN, 1, 2));
    // rt only counts when the ID instruction actually reads it
    step("rt_unused",   0, '{0, 4, 0, 0, 0, 4, 0, 1, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RUN, 1, 2));
    step("rt_used",     0, '{0, 4, 1, 0, 0, 4, 0, 1, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_STL, 1, 2));
    step("idle1",       0, idle,                                mkE(0, FWD_REG,   FWD_REG,   K_RUN, 2, 2));
    step("ld_zero",     0, '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0}, mkE(0, FWD_REG,   FWD_REG,   K_RUN, 2, 2));

    // Three-cycle stall instance
    step("hz3",         1, '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 0, 0));
    step("stall_a",     1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 1, 0));
    step("stall_b",     1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 2, 0));
    step("resume",      1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_RUN, 3, 0));
    step("hz3b",        1, '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 3, 0));
    step("redir_stall", 1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0}, mkE(1, FWD_REG, FWD_REG, K_RED, 4, 0));
    step("back_run",    1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_RUN, 4, 1));
    step("hz3c",        1, '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 4, 1));
    step("stall_c",     1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 5, 1));
    step("stall_d",     1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 6, 1));

    // Reset in the second STALL cycle releases the PC at once
    #1;
    RSTn = 1'b0;
    applyStimulus("rst_mid", 1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_RUN, 0, 0));
    #1;
    checkOutput();
    step("rst_hold",    1, '{8, 0, 0, 0, 0, 8, 1, 1, 1, 1, 1}, mkE(1, FWD_REG, FWD_REG, K_RUN, 0, 0));
    @(negedge CLK);
    setA(idle);
    setC(idle);
    RSTn = 1'b1;
    step("after_rst",   1, '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_RUN, 0, 0));
    step("hz_again",    1, '{8, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0}, mkE(1, FWD_REG, FWD_REG, K_STL, 0, 0));
    step("stall_e",     1, idle,                                mkE(1, FWD_REG, FWD_REG, K_STL, 1, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
